// File: rtl/sbox_word_sched.sv
// sbox_word_sched: round-robin scheduler sharing one combinational AES byte
// S-box between NREQ requesters. Each accepted word is fed through the S-box
// one byte per cycle (byte 0 first) and returned as SubWord with its id.
// Optional build macro SBOX_WORD_SCHED_ROTWORD_EN adds a per-requester
// req_rot input that rotates the word left by one byte (RotWord) at accept.
module sbox_word_sched #(
    parameter int NREQ  = 2,
    parameter int BYTES = 4,
    localparam int W    = 8 * BYTES,
    localparam int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req_valid,
    output logic [NREQ-1:0]     req_ready,
    input  logic [NREQ*W-1:0]   req_data,
`ifdef SBOX_WORD_SCHED_ROTWORD_EN
    input  logic [NREQ-1:0]     req_rot,
`endif
    output logic                resp_valid,
    input  logic                resp_ready,
    output logic [IDW-1:0]      resp_id,
    output logic [W-1:0]        resp_data,
    output logic [7:0]          sbox_in,
    input  logic [7:0]          sbox_out
);

    localparam int CW = $clog2(BYTES + 1);

    typedef enum logic [1:0] {IDLE, SUB, DONE} state_t;

    state_t          state_q;
    logic [W-1:0]    work_q;
    logic [W-1:0]    work_d;
    logic [CW-1:0]   byte_cnt_q;
    logic [IDW-1:0]  last_grant_q;
    logic [IDW-1:0]  resp_id_q;
    logic [W-1:0]    resp_data_q;
    logic [W-1:0]    resp_data_d;
    logic            resp_valid_q;
    logic [IDW-1:0]  grant;
    logic [IDW-1:0]  idx;
    logic            found;
    logic [W-1:0]    granted_word;
    logic [CW+2:0]   byte_sh;

    // Round-robin search starting just after the last requester served
    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = IDW'((int'(last_grant_q) + k) % NREQ);
            if (!found && req_valid[idx]) begin
                grant = idx;
                found = 1'b1;
            end
        end
    end

    // Accept handshake is offered only while idle; at most one bit set
    assign req_ready = (state_q == IDLE && found) ? (NREQ'(1) << grant) : '0;

    assign granted_word = W'(req_data >> (int'(grant) * W));

    // Word to be latched at accept, optionally rotated left by one byte
    always_comb begin
        work_d = granted_word;
`ifdef SBOX_WORD_SCHED_ROTWORD_EN
        if (req_rot[grant]) begin
            work_d = (granted_word << 8) | (granted_word >> (W - 8));
        end
`endif
    end

    assign byte_sh = {byte_cnt_q, 3'b000};

    // Current byte to the S-box; quiet (zero) when not substituting
    always_comb begin
        sbox_in     = 8'h00;
        resp_data_d = (resp_data_q & ~(W'(8'hFF) << byte_sh)) | (W'(sbox_out) << byte_sh);
        if (state_q == SUB) begin
            sbox_in = 8'(work_q >> byte_sh);
        end
    end

    // Scheduler FSM with registered response outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            resp_valid_q <= 1'b0;
            resp_id_q    <= '0;
            resp_data_q  <= '0;
            byte_cnt_q   <= '0;
            last_grant_q <= IDW'(NREQ - 1);
        end else begin
            case (state_q)
                IDLE: begin
                    if (found) begin
                        work_q     <= work_d;
                        resp_id_q  <= grant;
                        byte_cnt_q <= '0;
                        state_q    <= SUB;
                    end
                end
                SUB: begin
                    resp_data_q <= resp_data_d;
                    if (byte_cnt_q == CW'(BYTES - 1)) begin
                        byte_cnt_q   <= '0;
                        resp_valid_q <= 1'b1;
                        state_q      <= DONE;
                    end else begin
                        byte_cnt_q <= byte_cnt_q + CW'(1);
                    end
                end
                DONE: begin
                    if (resp_ready) begin
                        resp_valid_q <= 1'b0;
                        last_grant_q <= resp_id_q;
                        state_q      <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign resp_valid = resp_valid_q;
    assign resp_id    = resp_id_q;
    assign resp_data  = resp_data_q;

endmodule

// File: tb/tb_sbox_word_sched.sv
// Directed bench for sbox_word_sched: AES S-box environment model, vector
// table of single-word transactions, plus sequences for arbitration,
// back-pressure, mid-operation reset and a three-requester instance.
module tb_sbox_word_sched;

    localparam int NREQ  = 2;
    localparam int BYTES = 4;
    localparam int W     = 32;

    localparam logic [7:0] SBOX [0:255] = '{
        8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
        8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
        8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
        8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
        8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
        8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
        8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
        8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
        8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
        8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
        8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
        8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
        8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
        8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
        8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
        8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
    };

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*W-1:0] req_data;
    logic              resp_valid;
    logic              resp_ready;
    logic              resp_id;
    logic [W-1:0]      resp_data;
    logic [7:0]        sbox_in;
    logic [7:0]        sbox_out;

    logic [2:0]        req_valid3;
    logic [2:0]        req_ready3;
    logic [3*W-1:0]    req_data3;
    logic              resp_valid3;
    logic [1:0]        resp_id3;
    logic [W-1:0]      resp_data3;
    logic [7:0]        sbox_in3;
    logic [7:0]        sbox_out3;
`ifdef SBOX_WORD_SCHED_ROTWORD_EN
    logic [NREQ-1:0]   req_rot;
    logic [2:0]        req_rot3;
`endif

    always #5 clk = ~clk;

    assign sbox_out  = SBOX[sbox_in];
    assign sbox_out3 = SBOX[sbox_in3];

    sbox_word_sched #(.NREQ(NREQ), .BYTES(BYTES)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_data   (req_data),
`ifdef SBOX_WORD_SCHED_ROTWORD_EN
        .req_rot    (req_rot),
`endif
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_id    (resp_id),
        .resp_data  (resp_data),
        .sbox_in    (sbox_in),
        .sbox_out   (sbox_out)
    );

    sbox_word_sched #(.NREQ(3), .BYTES(BYTES)) dut3 (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid3),
        .req_ready  (req_ready3),
        .req_data   (req_data3),
`ifdef SBOX_WORD_SCHED_ROTWORD_EN
        .req_rot    (req_rot3),
`endif
        .resp_valid (resp_valid3),
        .resp_ready (resp_ready),
        .resp_id    (resp_id3),
        .resp_data  (resp_data3),
        .sbox_in    (sbox_in3),
        .sbox_out   (sbox_out3)
    );

    typedef struct {
        int          id;
        logic [31:0] data;
        logic        rot;
        logic [31:0] exp;
    } vec_t;

    vec_t vec [5];
    int   nvec;
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Starts at a negedge with the DUT idle; ends at a negedge, idle again
    task automatic run_word(input int id, input logic [31:0] data, input logic rot,
                            input logic [31:0] exp);
        logic [31:0] w;
        w = rot ? {data[23:0], data[31:24]} : data;
        req_valid = '0;
        req_valid[id] = 1'b1;
        req_data[id*W +: W] = data;
`ifdef SBOX_WORD_SCHED_ROTWORD_EN
        req_rot = '0;
        req_rot[id] = rot;
`endif
        #1 chk("vec_ready", req_ready, 64'(1) << id);
        @(posedge clk); #1 req_valid = '0;
        for (int b = 0; b < BYTES; b++) begin
            @(negedge clk);
            chk("vec_sbox_in", sbox_in, w[b*8 +: 8]);
            chk("vec_valid_early", resp_valid, 0);
            @(posedge clk);
        end
        @(negedge clk);
        chk("vec_resp_valid", resp_valid, 1);
        chk("vec_resp_id", resp_id, id);
        chk("vec_resp_data", resp_data, exp);
        @(posedge clk);
        @(negedge clk);
        chk("vec_resp_clear", resp_valid, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic got, bad;
        int   nacc, last_acc;

        vec[0] = '{0, 32'h00010253, 1'b0, 32'h637C77ED};
        vec[1] = '{1, 32'h10101010, 1'b0, 32'hCACACACA};
        vec[2] = '{0, 32'h000000FF, 1'b0, 32'h63636316};
        vec[3] = '{1, 32'h09CF4F3C, 1'b0, 32'h018A84EB};
        vec[4] = '{1, 32'h09CF4F3C, 1'b1, 32'h8A84EB01};
`ifdef SBOX_WORD_SCHED_ROTWORD_EN
        nvec = 5;
        req_rot  = '0;
        req_rot3 = '0;
`else
        nvec = 4;
`endif
        rst        = 1'b1;
        req_valid  = '0;
        req_data   = '0;
        resp_ready = 1'b1;
        req_valid3 = '0;
        req_data3  = '0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_resp_id", resp_id, 0);
        chk("rst_resp_data", resp_data, 0);
        chk("rst_sbox_in", sbox_in, 0);
        rst = 1'b0;

        // Vector table
        for (int i = 0; i < nvec; i++) begin
            run_word(vec[i].id, vec[i].data, vec[i].rot, vec[i].exp);
        end

        // Both requesters held valid: grants alternate starting with 0
        req_valid = 2'b11;
        req_data  = {32'h10101010, 32'h000000FF};
        bad = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1 chk("alt_grant", req_ready, (k % 2 == 1) ? 2'b10 : 2'b01);
            @(posedge clk);
            got = 1'b0;
            for (int c = 0; c < 10 && !got; c++) begin
                @(negedge clk);
                if (req_ready != '0) bad = 1'b1;
                if (resp_valid) got = 1'b1;
            end
            chk("alt_seen", got, 1);
            chk("alt_id", resp_id, k % 2);
            chk("alt_data", resp_data, (k % 2 == 1) ? 32'hCACACACA : 32'h63636316);
            @(posedge clk);
            @(negedge clk);
        end
        chk("alt_ready_excl", bad, 0);
        req_valid = '0;

        // Back-pressure in DONE while requester 1 waits
        req_data[31:0] = 32'h00010253;
        req_valid  = 2'b01;
        resp_ready = 1'b0;
        #1 chk("stall_grant", req_ready, 2'b01);
        @(posedge clk); #1 req_valid = 2'b10;
        got = 1'b0;
        for (int c = 0; c < 10 && !got; c++) begin
            @(negedge clk);
            if (resp_valid) got = 1'b1;
        end
        chk("stall_seen", got, 1);
        for (int s = 0; s < 5; s++) begin
            chk("stall_valid", resp_valid, 1);
            chk("stall_data", resp_data, 32'h637C77ED);
            chk("stall_id", resp_id, 0);
            chk("stall_ready", req_ready, 0);
            @(posedge clk);
            @(negedge clk);
        end
        chk("stall_valid_last", resp_valid, 1);
        resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("stall_done", resp_valid, 0);
        req_valid = '0;

        // Reset during the second SUB cycle of a requester-1 word
        req_valid = 2'b10;
        #1 chk("mrst_grant", req_ready, 2'b10);
        @(posedge clk); #1 req_valid = '0;
        @(negedge clk);
        chk("mrst_sbox0", sbox_in, 8'h10);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("mrst_resp_valid", resp_valid, 0);
        chk("mrst_req_ready", req_ready, 0);
        chk("mrst_sbox_in", sbox_in, 0);
        chk("mrst_resp_id", resp_id, 0);
        chk("mrst_resp_data", resp_data, 0);
        bad = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (resp_valid) bad = 1'b1;
        end
        chk("mrst_no_resp", bad, 0);
        req_valid = 2'b11;
        #1 chk("mrst_regrant", req_ready, 2'b01);
        @(posedge clk); #1 req_valid = '0;
        got = 1'b0;
        for (int c = 0; c < 10 && !got; c++) begin
            @(negedge clk);
            if (resp_valid) got = 1'b1;
        end
        chk("mrst_seen", got, 1);
        chk("mrst_id", resp_id, 0);
        chk("mrst_data", resp_data, 32'h637C77ED);
        @(posedge clk);
        @(negedge clk);

        // Three requesters, only requester 2 valid: accepts every 6 cycles
        req_data3[2*W +: W] = 32'h10101010;
        req_valid3 = 3'b100;
        nacc = 0;
        last_acc = 0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge clk);
            if (req_ready3 != '0) begin
                chk("r3_grant", req_ready3, 3'b100);
                if (nacc > 0) chk("r3_spacing", cyc - last_acc, BYTES + 2);
                last_acc = cyc;
                nacc++;
            end
            if (resp_valid3) begin
                chk("r3_id", resp_id3, 2);
                chk("r3_data", resp_data3, 32'hCACACACA);
            end
        end
        chk("r3_count", (nacc >= 3), 1);
        req_valid3 = '0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
